// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: instruction field layout,
// opcode values and FSM state encoding.
package core_pkg;

  localparam int unsigned INSTR_W  = 20;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned IMM_W    = 10;

  localparam int unsigned OPC_MSB = 19;
  localparam int unsigned OPC_LSB = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 13;
  localparam int unsigned RS_MSB  = 12;
  localparam int unsigned RS_LSB  = 10;
  localparam int unsigned IMM_MSB = 9;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_LDM  = 4'b0011,
    OP_STM  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_MOV  = 4'b0110,
    OP_LDI  = 4'b0111,
    OP_JMP  = 4'b1000,
    OP_JZ   = 4'b1001,
    OP_HALT = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  function automatic logic [3:0] f_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] f_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [IMM_W-1:0] f_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 8-entry register file, two combinational read ports and one clocked write
// port; r0 is hardwired to zero.
module core_regfile
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multi_cycle_core.sv
// Multi-cycle accumulator-style core: FETCH -> EXEC -> (MEM) -> FETCH,
// with a single-request data-memory port and a sticky HALT state.
module multi_cycle_core
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PC_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  input  logic               mem_ack_i,
  output logic               halted_o
);

  state_e             state, state_nx;
  logic [INSTR_W-1:0] ir, ir_nx;
  logic [PC_W-1:0]    pc, pc_nx, pc_inc;
  logic               mem_we, mem_we_nx;
  logic [ADDR_W-1:0]  mem_addr, mem_addr_nx;
  logic [DATA_W-1:0]  mem_wdata, mem_wdata_nx;

  logic [3:0]         opc;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  rd_val, rs_val;
  logic               rf_we;
  logic [DATA_W-1:0]  rf_wdata;

  assign opc    = f_opcode(ir);
  assign imm    = f_imm(ir);
  assign pc_inc = pc + PC_W'(1);

  core_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (f_rd(ir)),
    .rdata_a (rd_val),
    .raddr_b (f_rs(ir)),
    .rdata_b (rs_val),
    .we      (rf_we),
    .waddr   (f_rd(ir)),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      pc        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ir        <= ir_nx;
      pc        <= pc_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ir_nx        = ir;
    pc_nx        = pc;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    rf_we        = 1'b0;
    rf_wdata     = '0;

    case (state)
      S_FETCH: begin
        if (instr_valid_i) begin
          ir_nx    = instr_i;
          state_nx = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nx = S_FETCH;
        pc_nx    = pc_inc;
        case (opc)
          OP_ADD: begin rf_we = 1'b1; rf_wdata = rd_val + rs_val; end
          OP_SUB: begin rf_we = 1'b1; rf_wdata = rd_val - rs_val; end
          OP_AND: begin rf_we = 1'b1; rf_wdata = rd_val & rs_val; end
          OP_MOV: begin rf_we = 1'b1; rf_wdata = rs_val; end
          OP_LDI: begin rf_we = 1'b1; rf_wdata = DATA_W'(imm); end
          OP_JMP: pc_nx = PC_W'(imm);
          OP_JZ:  if (rd_val == '0) pc_nx = PC_W'(imm);
          // Address, direction and store data are captured here so they
          // hold steady for however many wait states MEM lasts.
          OP_LDM, OP_STM: begin
            state_nx     = S_MEM;
            pc_nx        = pc;
            mem_we_nx    = (opc == OP_STM);
            mem_addr_nx  = ADDR_W'(imm);
            mem_wdata_nx = rd_val;
          end
          OP_HALT: begin
            state_nx = S_HALT;
            pc_nx    = pc;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        if (mem_ack_i) begin
          state_nx = S_FETCH;
          pc_nx    = pc_inc;
          if (!mem_we) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata_i;
          end
        end
      end

      S_HALT: ;

      default: state_nx = S_FETCH;
    endcase
  end

  assign pc_o        = pc;
  assign mem_req_o   = (state == S_MEM);
  assign mem_we_o    = mem_we;
  assign mem_addr_o  = mem_addr;
  assign mem_wdata_o = mem_wdata;
  assign halted_o    = (state == S_HALT);

endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: runs a small program from a bench-side
// instruction ROM and answers data-memory requests with scripted wait states.
module tb_multi_cycle_core;
  import core_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned PC_W   = 6;

  logic               clk;
  logic               rst_n;
  logic [INSTR_W-1:0] instr_i;
  logic               instr_valid_i;
  logic [PC_W-1:0]    pc_o;
  logic               mem_req_o;
  logic               mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [DATA_W-1:0]  mem_wdata_o;
  logic [DATA_W-1:0]  mem_rdata_i;
  logic               mem_ack_i;
  logic               halted_o;

  logic [INSTR_W-1:0] rom [64];
  int unsigned n_cmp;
  int unsigned n_err;

  multi_cycle_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .PC_W   (PC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .pc_o          (pc_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_ack_i     (mem_ack_i),
    .halted_o      (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input int unsigned rd,
                                             input int unsigned rs, input int unsigned imm);
    return {op, 3'(rd), 3'(rs), 10'(imm)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    instr_i = rom[pc_o];
  endtask

  // Runs one LDM/STM from FETCH to completion, acking after 'waits' stall cycles.
  task automatic mem_txn(input string tag, input int unsigned waits, input logic [31:0] rdata,
                         input logic exp_we, input logic [11:0] exp_addr,
                         input logic [31:0] exp_wdata, input bit chk_wdata);
    int unsigned n;
    n = 0;
    step();
    step();
    while (mem_req_o && n < 50) begin
      n++;
      check_eq({tag, "_we"}, 64'(mem_we_o), 64'(exp_we));
      check_eq({tag, "_addr"}, 64'(mem_addr_o), 64'(exp_addr));
      if (chk_wdata) check_eq({tag, "_wdata"}, 64'(mem_wdata_o), 64'(exp_wdata));
      mem_ack_i   = (n == waits + 1);
      mem_rdata_i = mem_ack_i ? rdata : 32'hDEAD_BEEF;
      step();
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hDEAD_BEEF;
    check_eq({tag, "_req_cycles"}, 64'(n), 64'(waits + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    instr_valid_i = 1'b1;
    mem_ack_i     = 1'b0;
    mem_rdata_i   = 32'hDEAD_BEEF;

    for (int i = 0; i < 64; i++) rom[i] = enc(OP_NOP, 0, 0, 0);
    rom[0]  = enc(OP_LDI, 1, 0, 12);
    rom[1]  = enc(OP_LDI, 2, 0, 20);
    rom[2]  = enc(OP_ADD, 1, 2, 0);
    rom[3]  = enc(OP_STM, 1, 0, 5);
    rom[4]  = enc(OP_LDM, 3, 0, 7);
    rom[5]  = enc(OP_STM, 3, 0, 9);
    rom[6]  = enc(OP_JZ,  1, 0, 40);
    rom[7]  = enc(OP_SUB, 2, 1, 0);
    rom[8]  = enc(OP_MOV, 4, 2, 0);
    rom[9]  = enc(OP_AND, 4, 1, 0);
    rom[10] = enc(OP_LDI, 0, 0, 5);
    rom[11] = enc(OP_STM, 4, 0, 16);
    rom[12] = enc(OP_STM, 0, 0, 17);
    rom[13] = enc(OP_STM, 2, 0, 18);
    rom[14] = enc(4'b1010, 1, 1, 0);
    rom[15] = enc(OP_JMP, 0, 0, 20);
    rom[20] = enc(OP_JZ,  0, 0, 63);
    instr_i = rom[0];

    #12;
    check_eq("rst_pc", 64'(pc_o), 64'd0);
    check_eq("rst_req", 64'(mem_req_o), 64'd0);
    check_eq("rst_we", 64'(mem_we_o), 64'd0);
    check_eq("rst_addr", 64'(mem_addr_o), 64'd0);
    check_eq("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check_eq("rst_halted", 64'(halted_o), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("first_fetch_pc", 64'(pc_o), 64'd0);
    step();
    check_eq("ldi_pc", 64'(pc_o), 64'd1);
    repeat (4) step();
    check_eq("add_pc", 64'(pc_o), 64'd3);

    mem_txn("stm_r1", 3, 32'h0, 1'b1, 12'd5, 32'd32, 1'b1);
    check_eq("stm_r1_pc", 64'(pc_o), 64'd4);
    mem_txn("ldm_r3", 0, 32'h4B, 1'b0, 12'd7, 32'h0, 1'b0);
    check_eq("ldm_r3_pc", 64'(pc_o), 64'd5);
    mem_txn("stm_r3", 1, 32'h0, 1'b1, 12'd9, 32'h4B, 1'b1);
    check_eq("stm_r3_pc", 64'(pc_o), 64'd6);

    step(); step();
    check_eq("jz_not_taken_pc", 64'(pc_o), 64'd7);
    repeat (8) step();
    check_eq("alu_seq_pc", 64'(pc_o), 64'd11);
    mem_txn("stm_and", 0, 32'h0, 1'b1, 12'd16, 32'h20, 1'b1);
    mem_txn("stm_r0", 0, 32'h0, 1'b1, 12'd17, 32'h0, 1'b1);
    mem_txn("stm_sub", 0, 32'h0, 1'b1, 12'd18, 32'hFFFF_FFF4, 1'b1);

    step(); step();
    check_eq("undef_op_pc", 64'(pc_o), 64'd15);
    check_eq("undef_op_halted", 64'(halted_o), 64'd0);
    step(); step();
    check_eq("jmp_pc", 64'(pc_o), 64'd20);
    step(); step();
    check_eq("jz_taken_pc", 64'(pc_o), 64'd63);
    step(); step();
    check_eq("pc_wrap", 64'(pc_o), 64'd0);

    repeat (6) step();
    check_eq("rerun_pc", 64'(pc_o), 64'd3);
    step(); step();
    check_eq("pre_rst_req", 64'(mem_req_o), 64'd1);
    check_eq("pre_rst_wdata", 64'(mem_wdata_o), 64'd32);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_mem_rst_req", 64'(mem_req_o), 64'd0);
    check_eq("mid_mem_rst_pc", 64'(pc_o), 64'd0);
    check_eq("mid_mem_rst_we", 64'(mem_we_o), 64'd0);
    check_eq("mid_mem_rst_addr", 64'(mem_addr_o), 64'd0);
    check_eq("mid_mem_rst_wdata", 64'(mem_wdata_o), 64'd0);

    rom[0] = enc(OP_STM, 1, 0, 21);
    rom[1] = enc(OP_STM, 4, 0, 22);
    rom[2] = enc(OP_HALT, 0, 0, 0);
    rom[3] = enc(OP_STM, 2, 0, 23);
    instr_i = rom[0];
    @(negedge clk);
    rst_n = 1'b1;

    mem_txn("post_rst_r1", 0, 32'h0, 1'b1, 12'd21, 32'h0, 1'b1);
    mem_txn("post_rst_r4", 0, 32'h0, 1'b1, 12'd22, 32'h0, 1'b1);
    check_eq("pre_halt_pc", 64'(pc_o), 64'd2);
    step(); step();
    check_eq("halt_entry", 64'(halted_o), 64'd1);
    check_eq("halt_entry_pc", 64'(pc_o), 64'd2);

    for (int i = 0; i < 10; i++) begin
      instr_valid_i = 1'b1;
      mem_ack_i     = 1'b1;
      step();
      instr_i = enc(OP_STM, 2, 0, 23);
      check_eq("halt_hold", 64'(halted_o), 64'd1);
      check_eq("halt_pc", 64'(pc_o), 64'd2);
      check_eq("halt_no_req", 64'(mem_req_o), 64'd0);
    end
    mem_ack_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
